// File: rtl/hamming_sum_gen_if.sv
// Block-input / Hamming-sum-output bundle for hamming_sum_gen.
// master drives blocks in and consumes sums; slave is the generator itself.
interface hamming_sum_gen_if #(
  parameter int unsigned blk_h        = 16,
  parameter int unsigned blk_w        = 16,
  parameter int unsigned search_blk_w = 64,
  parameter int unsigned search_blk_h = 20
);
  localparam int unsigned blk_size = blk_h * blk_w;
  localparam int unsigned win_size = search_blk_w * search_blk_h;

  logic [blk_size-1:0] ref_blk;
  logic [win_size-1:0] search_win;
  logic [15:0]         blk_index_i;
  logic                blk_in_valid;
  logic                blk_in_ready;
  logic [blk_size-1:0] xors;
  logic [7:0]          sum;
  logic [15:0]         out_coords;
  logic [15:0]         blk_index_o;
  logic                sum_valid;
  logic                busy;

  modport master (
    output ref_blk, search_win, blk_index_i, blk_in_valid,
    input  blk_in_ready, xors, sum, out_coords, blk_index_o, sum_valid, busy
  );

  modport slave (
    input  ref_blk, search_win, blk_index_i, blk_in_valid,
    output blk_in_ready, xors, sum, out_coords, blk_index_o, sum_valid, busy
  );
endinterface

// File: rtl/hamming_sum_gen.sv
// Scans every (v,h) offset of a census reference block over its search window and emits
// one XOR vector / saturated popcount per clock, ending on {V-1,0} for min_dist_finder.
module hamming_sum_gen #(
  parameter int unsigned blk_h        = 16,
  parameter int unsigned blk_w        = 16,
  parameter int unsigned search_blk_w = 64,
  parameter int unsigned search_blk_h = 20,
  parameter int unsigned gap_cycles   = 2
) (
  input logic              clk,
  input logic              reset,
  hamming_sum_gen_if.slave bus
);
  localparam int unsigned blk_size = blk_h * blk_w;
  localparam int unsigned win_size = search_blk_w * search_blk_h;
  localparam int unsigned V  = search_blk_h - blk_h;
  localparam int unsigned H  = search_blk_w - blk_w;
  localparam int unsigned VW = (V > 1) ? $clog2(V) : 1;
  localparam int unsigned HW = (H > 1) ? $clog2(H) : 1;
  localparam int unsigned GW = (gap_cycles > 1) ? $clog2(gap_cycles) : 1;
  localparam int unsigned SW = $clog2(win_size);
  localparam int unsigned CW = $clog2(blk_size + 1);

  if (search_blk_h <= blk_h || search_blk_w <= blk_w || gap_cycles < 2) begin : gen_bad_params
    $error("hamming_sum_gen: empty offset range or gap_cycles < 2");
  end

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StGap} state_e;

  state_e state_q, state_d;
  logic [VW-1:0] v_q, v_d;
  logic [HW-1:0] h_q, h_d;
  logic [GW-1:0] gap_q, gap_d;

  logic [blk_size-1:0] ref_q, ref_d;
  logic [win_size-1:0] win_q, win_d;
  logic [15:0]         idx_q, idx_d;

  logic                s1_valid_q, s1_valid_d;
  logic [blk_size-1:0] s1_xors_q, s1_xors_d;
  logic [15:0]         s1_coords_q, s1_coords_d;
  logic [15:0]         s1_idx_q, s1_idx_d;

  logic                sum_valid_q, sum_valid_d;
  logic [blk_size-1:0] xors_q, xors_d;
  logic [7:0]          sum_q, sum_d;
  logic [15:0]         coords_q, coords_d;
  logic [15:0]         idx_o_q, idx_o_d;

  logic                ready;
  logic                accept;
  logic                issue;
  logic [SW-1:0]       shamt;
  logic [win_size-1:0] shifted;
  logic [blk_size-1:0] cand;
  logic [CW-1:0]       cnt;

  assign ready  = (state_q == StIdle) && !reset;
  assign accept = bus.blk_in_valid && ready;

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    h_d     = h_q;
    gap_d   = gap_q;
    issue   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StScan;
          v_d     = '0;
          h_d     = HW'(H - 1);
        end
      end
      StScan: begin
        issue = 1'b1;
        if (h_q == '0) begin
          h_d = HW'(H - 1);
          if (v_q == VW'(V - 1)) state_d = StDrain;
          else                   v_d     = v_q + 1'b1;
        end else begin
          h_d = h_q - 1'b1;
        end
      end
      // Stage 1 empty means the final sum is sitting in stage 2 this cycle.
      StDrain: begin
        if (!s1_valid_q) begin
          state_d = StGap;
          gap_d   = '0;
        end
      end
      StGap: begin
        if (gap_q == GW'(gap_cycles - 1)) state_d = StIdle;
        else                              gap_d   = gap_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Shifting the window so that (v,h) lands at bit 0 turns the extract into fixed wiring.
  always_comb begin
    shamt   = SW'(v_q) * SW'(search_blk_w) + SW'(h_q);
    shifted = win_q >> shamt;
    cand    = '0;
    for (int unsigned r = 0; r < blk_h; r++) begin
      for (int unsigned c = 0; c < blk_w; c++) begin
        cand[r*blk_w+c] = shifted[r*search_blk_w+c];
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < blk_size; i++) begin
      cnt = cnt + CW'(s1_xors_q[i]);
    end
  end

  always_comb begin
    ref_d       = accept ? bus.ref_blk     : ref_q;
    win_d       = accept ? bus.search_win  : win_q;
    idx_d       = accept ? bus.blk_index_i : idx_q;
    s1_valid_d  = issue;
    s1_xors_d   = ref_q ^ cand;
    s1_coords_d = {8'(v_q), 8'(h_q)};
    s1_idx_d    = idx_q;
    sum_valid_d = s1_valid_q;
    xors_d      = xors_q;
    sum_d       = sum_q;
    coords_d    = coords_q;
    idx_o_d     = idx_o_q;
    if (s1_valid_q) begin
      xors_d   = s1_xors_q;
      sum_d    = (int'(cnt) > 255) ? 8'hFF : 8'(cnt);
      coords_d = s1_coords_q;
      idx_o_d  = s1_idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      v_q         <= '0;
      h_q         <= '0;
      gap_q       <= '0;
      s1_valid_q  <= 1'b0;
      sum_valid_q <= 1'b0;
      xors_q      <= '0;
      sum_q       <= '0;
      coords_q    <= '0;
      idx_o_q     <= '0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      h_q         <= h_d;
      gap_q       <= gap_d;
      s1_valid_q  <= s1_valid_d;
      sum_valid_q <= sum_valid_d;
      xors_q      <= xors_d;
      sum_q       <= sum_d;
      coords_q    <= coords_d;
      idx_o_q     <= idx_o_d;
    end
  end

  // Payload registers are qualified by the valid flops, so they need no reset.
  always_ff @(posedge clk) begin
    ref_q       <= ref_d;
    win_q       <= win_d;
    idx_q       <= idx_d;
    s1_xors_q   <= s1_xors_d;
    s1_coords_q <= s1_coords_d;
    s1_idx_q    <= s1_idx_d;
  end

  assign bus.blk_in_ready = ready;
  assign bus.xors         = xors_q;
  assign bus.sum          = sum_q;
  assign bus.out_coords   = coords_q;
  assign bus.blk_index_o  = idx_o_q;
  assign bus.sum_valid    = sum_valid_q;
  assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_hamming_sum_gen.sv
// Randomized bench for hamming_sum_gen: a per-offset reference model builds the expected
// sum stream at acceptance; a negedge monitor checks every output cycle plus timing.
module tb_hamming_sum_gen;
  localparam int BW = 16;
  localparam int BH = 16;
  localparam int SWD = 64;
  localparam int V = 4;
  localparam int H = 48;
  localparam int NS = V * H;

  typedef logic [255:0]  blk_t;
  typedef logic [1279:0] win_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  hamming_sum_gen_if bus ();

  hamming_sum_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic blk_t model_xor(input blk_t r, input win_t w, input int v, input int h);
    blk_t x;
    for (int rr = 0; rr < BH; rr++)
      for (int cc = 0; cc < BW; cc++)
        x[rr*BW+cc] = r[rr*BW+cc] ^ w[(rr+v)*SWD+cc+h];
    return x;
  endfunction

  function automatic int model_sum(input blk_t x);
    int n;
    n = $countones(x);
    return (n > 255) ? 255 : n;
  endfunction

  function automatic blk_t rand_blk();
    blk_t b;
    for (int i = 0; i < 8; i++) b[i*32+:32] = $urandom;
    return b;
  endfunction

  function automatic win_t rand_win();
    win_t w;
    for (int i = 0; i < 40; i++) w[i*32+:32] = $urandom;
    return w;
  endfunction

  // Expected stream and monitor state
  blk_t        exp_x[$];
  int          exp_s[$];
  logic [15:0] exp_c[$];
  logic [15:0] exp_i[$];
  int          acc_q[$];
  int rx_cnt = 0;
  int blocks_done = 0;
  int last_sum_cyc = 0;
  bit have_last = 0;
  int busy_from = 1;
  int busy_until = 0;
  int last_acc = 0;
  int zero_cnt = 0;
  int sat_cnt = 0;
  logic [15:0] zero_coord = '0;
  blk_t zero_xors = '0;

  always @(negedge clk) begin
    bit in_win;
    in_win = (cyc >= busy_from) && (cyc <= busy_until);
    chk("busy", 256'(bus.busy), 256'(in_win));
    chk("blk_in_ready", 256'(bus.blk_in_ready), 256'(!reset && !in_win));
    if (bus.sum_valid) begin
      if (exp_s.size() == 0) begin
        chki("unexpected_sum_valid", 1, 0);
      end else begin
        chk("sum", 256'(bus.sum), 256'(exp_s.pop_front()));
        chk("out_coords", 256'(bus.out_coords), 256'(exp_c.pop_front()));
        chk("blk_index_o", 256'(bus.blk_index_o), 256'(exp_i.pop_front()));
        chk("xors", bus.xors, exp_x.pop_front());
        if (bus.sum == 8'd0) begin
          zero_cnt++;
          zero_coord = bus.out_coords;
          zero_xors  = bus.xors;
        end
        if (bus.sum == 8'd255) sat_cnt++;
        if (rx_cnt == 0) begin
          chki("first_sum_cycle", cyc, acc_q[0] + 3);
          if (have_last) chki("gap_after_last_sum", int'((cyc - last_sum_cyc) >= 3), 1);
        end
        if (rx_cnt == NS - 1) begin
          chki("last_sum_cycle", cyc, acc_q[0] + NS + 2);
          void'(acc_q.pop_front());
          last_sum_cyc = cyc;
          have_last = 1;
          rx_cnt = 0;
          blocks_done++;
        end else begin
          rx_cnt++;
        end
      end
    end
    if (bus.blk_in_valid && bus.blk_in_ready) begin
      for (int v = 0; v < V; v++) begin
        for (int h = H - 1; h >= 0; h--) begin
          blk_t x;
          x = model_xor(bus.ref_blk, bus.search_win, v, h);
          exp_x.push_back(x);
          exp_s.push_back(model_sum(x));
          exp_c.push_back({8'(v), 8'(h)});
          exp_i.push_back(bus.blk_index_i);
        end
      end
      acc_q.push_back(cyc);
      last_acc   = cyc;
      busy_from  = cyc + 1;
      busy_until = cyc + NS + 4;
    end
    // Reset takes effect at the coming edge: everything still in flight is void.
    if (reset) begin
      exp_x.delete();
      exp_s.delete();
      exp_c.delete();
      exp_i.delete();
      acc_q.delete();
      rx_cnt = 0;
      have_last = 0;
      busy_until = cyc;
    end
  end

  task automatic send(input blk_t r, input win_t w, input logic [15:0] idx, input bit hold);
    bit got;
    bus.ref_blk = r;
    bus.search_win = w;
    bus.blk_index_i = idx;
    bus.blk_in_valid = 1'b1;
    got = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      got = bus.blk_in_ready;
      @(posedge clk);
      #1;
    end
    if (!got) chki("accept_timeout", 0, 1);
    // Scramble inputs: the captured block must be unaffected.
    bus.ref_blk = rand_blk();
    bus.search_win = rand_win();
    bus.blk_index_i = 16'($urandom);
    bus.blk_in_valid = hold;
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (blocks_done < target && k < 600) begin
      @(posedge clk);
      #1;
      k++;
    end
    chki("block_complete", blocks_done, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t ones_b, zero_b, r;
    win_t ones_w, w;
    int   tA, tB, base, k, n;

    ones_b = '1;
    zero_b = '0;
    ones_w = '1;
    bus.ref_blk = '0;
    bus.search_win = '0;
    bus.blk_index_i = '0;
    bus.blk_in_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 256'(bus.blk_in_ready), 256'(0));
    chk("rst_sum_valid", 256'(bus.sum_valid), 256'(0));
    chk("rst_busy", 256'(bus.busy), 256'(0));
    chk("rst_sum", 256'(bus.sum), 256'(0));
    chk("rst_out_coords", 256'(bus.out_coords), 256'(0));
    chk("rst_blk_index_o", 256'(bus.blk_index_o), 256'(0));
    chk("rst_xors", bus.xors, 256'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 256'(bus.blk_in_ready), 256'(1));

    // Model pins
    chki("pin_model_identical", model_sum(model_xor(ones_b, ones_w, 0, 47)), 0);
    chki("pin_model_saturate", model_sum(model_xor(zero_b, ones_w, 3, 0)), 255);

    // Identical data
    zero_cnt = 0;
    send(ones_b, ones_w, 16'h0011, 0);
    chk("pin_first_coord", 256'(exp_c[0]), 256'(16'h002F));
    chk("pin_row_end_coord", 256'(exp_c[47]), 256'(16'h0000));
    chk("pin_row2_coord", 256'(exp_c[48]), 256'(16'h012F));
    chk("pin_last_coord", 256'(exp_c[NS-1]), 256'(16'h0300));
    wait_done(1);
    chki("identical_zero_count", zero_cnt, NS);

    // Single match at v=2, h=10
    r = rand_blk();
    for (int rr = 0; rr < 20; rr++)
      for (int cc = 0; cc < SWD; cc++)
        w[rr*SWD+cc] = ~r[(rr%BH)*BW + (cc%BW)];
    for (int rr = 0; rr < BH; rr++)
      for (int cc = 0; cc < BW; cc++)
        w[(rr+2)*SWD+cc+10] = r[rr*BW+cc];
    chki("pin_model_match", model_sum(model_xor(r, w, 2, 10)), 0);
    zero_cnt = 0;
    send(r, w, 16'h0022, 0);
    wait_done(2);
    chki("match_zero_count", zero_cnt, 1);
    chk("match_coord", 256'(zero_coord), 256'(16'h020A));
    chk("match_xors", zero_xors, 256'(0));

    // Saturation
    sat_cnt = 0;
    send(zero_b, ones_w, 16'h0033, 0);
    wait_done(3);
    chki("saturate_count", sat_cnt, NS);

    // Back-to-back with valid held
    send(rand_blk(), rand_win(), 16'h0001, 1);
    tA = last_acc;
    send(rand_blk(), rand_win(), 16'h0002, 0);
    tB = last_acc;
    chki("b2b_accept_spacing", tB - tA, NS + 5);
    wait_done(5);

    // Random blocks
    for (int i = 0; i < 3; i++) begin
      send(rand_blk(), rand_win(), 16'($urandom), 0);
      wait_done(6 + i);
    end

    // Reset on the 50th sum_valid
    base = blocks_done;
    send(rand_blk(), rand_win(), 16'h0044, 0);
    k = 0;
    while (!(bus.sum_valid && rx_cnt == 49) && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    chki("reach_50th_sum", int'(bus.sum_valid && rx_cnt == 49), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_kills_sum_valid", 256'(bus.sum_valid), 256'(0));
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.sum_valid) n++;
    end
    chki("no_sums_after_reset", n, 0);
    chki("no_block_after_reset", blocks_done, base);
    send(rand_blk(), rand_win(), 16'h0055, 0);
    wait_done(base + 1);

    repeat (10) @(posedge clk);
    #1;
    chki("expect_queue_empty", exp_s.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hamming_sum_gen.md
Name: hamming_sum_gen

Overview:
- Upstream feeder of min_dist_finder in the block-matching pipeline.
- Accepts one binary (census) reference block and its binary search window, then scans every candidate offset.
- Per offset: emits the XOR vector, a saturated popcount `sum`, the offset coordinates and the block index, one result per clock.
- Output port names and ordering match min_dist_finder's inputs so the two blocks connect directly.

Parameters:
- blk_h, 16, reference block height in rows
- blk_w, 16, reference block width in columns
- search_blk_w, 64, search window width in columns
- search_blk_h, 20, search window height in rows
- blk_size, blk_h*blk_w, bits per reference block
- win_size, search_blk_w*search_blk_h, bits per search window
- gap_cycles, 2, idle cycles forced after each block's last sum; minimum 2

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ref_blk  in  blk_size  reference bits; bit r*blk_w+c = row r, column c
- search_win  in  win_size  window bits; bit r*search_blk_w+c = row r, column c
- blk_index_i  in  16  block index tag
- blk_in_valid  in  1  input block presented
- blk_in_ready  out  1  block can be accepted
- xors  out  blk_size  ref_blk XOR candidate window
- sum  out  8  popcount of xors, saturated to 255
- out_coords  out  16  [15:8] vertical offset v, [7:0] horizontal offset h
- blk_index_o  out  16  blk_index_i of the block being scanned
- sum_valid  out  1  xors/sum/out_coords/blk_index_o are valid this cycle
- busy  out  1  high from acceptance until the GAP state ends

Behaviour:
- Offset ranges: V = search_blk_h-blk_h (default 4) and H = search_blk_w-blk_w (default 48); V*H sums per block (default 192).
- Candidate window at (v,h): bit r*blk_w+c = search_win[(r+v)*search_blk_w + c+h].
- Scan order:
  - v ascending 0..V-1 (outer); h descending H-1..0 (inner).
  - The final sum of a block is therefore {V-1, 0}, which is the terminal coordinate min_dist_finder expects.
- Accept on blk_in_valid && blk_in_ready. ref_blk, search_win and blk_index_i are registered at acceptance; later input changes have no effect.
- FSM:
  - IDLE: blk_in_ready=1. Acceptance -> SCAN with v=0, h=H-1.
  - SCAN: issue one offset per cycle. After issuing {V-1,0} -> DRAIN.
  - DRAIN: wait until the last issued sum has left the pipeline -> GAP.
  - GAP: count gap_cycles with sum_valid=0 -> IDLE.
- blk_in_ready is high only in IDLE; no overlap between blocks.
- Pipeline, 2 cycles from offset issue to sum_valid:
  - Stage 1 registers the window extract and XOR.
  - Stage 2 registers the popcount.
  - xors, out_coords and blk_index_o are delayed to stay aligned with sum.
- First sum_valid is 3 cycles after acceptance (1 cycle to enter SCAN + 2 pipeline).
- sum_valid is high for exactly V*H consecutive cycles per block. There is no backpressure; the downstream must consume every cycle.
- Arithmetic:
  - popcount range is 0..blk_size; a count of 256 or more outputs 255.
  - Counters are $clog2 sized.
  - out_coords fields are zero-extended to 8 bits.
- The GAP is needed because min_dist_finder re-arms (min_sum_sent) two cycles after its terminal sum. No first sum of a new block may appear earlier than gap_cycles+1 cycles after the previous last sum.
- Reset values: blk_in_ready=0 during reset and 1 the cycle after. sum_valid=0, busy=0, sum=0, out_coords=0, blk_index_o=0, xors=0, FSM=IDLE.
- Reset mid-scan: aborts immediately with no further sum_valid; any pipelined results are discarded.
- Degenerate V=0 or H=0 is illegal; flag it at elaboration.

Test Plan:
- Identical data: ref_blk all ones, search_win all ones -> 192 sum_valid cycles, each sum=0. Coordinates run {0,47},{0,46}…{0,0},{1,47}…{3,0}.
- Single match: ref_blk = random R; window region at v=2,h=10 equals R, all other window bits = ~R-pattern. -> sum=0 only at out_coords=16'h020A; xors at that cycle = 0.
- Saturation: ref_blk all zeros, search_win all ones -> every sum=255 (popcount 256 saturated); xors all ones.
- Timing: accept at cycle T -> first sum_valid at T+3, last at T+194. blk_in_ready returns at T+197. Hold blk_in_valid continuously; next first sum_valid is no earlier than T+200.
- Back-to-back into min_dist_finder: two blocks with indices 0x001 and 0x002 and distinct best offsets -> two min_sum_valid pulses with the correct coordinates and no cross-block min contamination.
- Reset at the 50th sum_valid -> sum_valid low next cycle and no further pulses. A new block accepted after reset produces a complete 192-sum scan.
